// File: rtl/ss_pkg.sv
// Shared types and compare helper for the selection-sort controller.
package ss_pkg;

    localparam int CMP_W = 65;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        RD_I   = 4'd1,
        CAP_I  = 4'd2,
        SCAN   = 4'd3,
        DRAIN  = 4'd4,
        SWAP_A = 4'd5,
        SWAP_B = 4'd6,
        NEXT   = 4'd7,
        DONE   = 4'd8
    } ss_state_e;

    // Operands arrive already extended to CMP_W according to signedness; strict compare so ties lose.
    function automatic logic ss_wins(input logic ascend,
                                     input logic signed [CMP_W-1:0] cand,
                                     input logic signed [CMP_W-1:0] cur);
        return ascend ? (cand < cur) : (cand > cur);
    endfunction

endpackage

// File: rtl/SS_detect_edge.sv
// Registered-history edge detector; POS_EDGE selects rising or falling edge.
module SS_detect_edge #(
    parameter bit POS_EDGE = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sig,
    output logic o_edge
);
    logic r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_prev <= 1'b0;
        else          r_prev <= i_sig;
    end

    assign o_edge = POS_EDGE ? (i_sig & ~r_prev) : (~i_sig & r_prev);
endmodule

// File: rtl/ss_sort_ctrl_cmp_min.sv
// Running min/max tracker: load seeds it, a valid candidate replaces it when it strictly wins.
import ss_pkg::*;

module ss_cmp_min #(
    parameter int DATA_W = 8,
    parameter int IDX_W  = 5,
    parameter bit ASCEND = 1'b1,
    parameter bit SIGNED = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_load_val,
    input  logic [IDX_W-1:0]  i_load_idx,
    input  logic              i_cand_vld,
    input  logic [DATA_W-1:0] i_cand_val,
    input  logic [IDX_W-1:0]  i_cand_idx,
    output logic              o_win,
    output logic [DATA_W-1:0] o_min_val,
    output logic [IDX_W-1:0]  o_min_idx
);
    logic signed [CMP_W-1:0] w_cand_x;
    logic signed [CMP_W-1:0] w_cur_x;

    assign w_cand_x = {{(CMP_W-DATA_W){SIGNED & i_cand_val[DATA_W-1]}}, i_cand_val};
    assign w_cur_x  = {{(CMP_W-DATA_W){SIGNED & o_min_val[DATA_W-1]}}, o_min_val};
    assign o_win    = i_cand_vld & ss_wins(ASCEND, w_cand_x, w_cur_x);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_min_val <= '0;
            o_min_idx <= '0;
        end else if (i_load) begin
            o_min_val <= i_load_val;
            o_min_idx <= i_load_idx;
        end else if (o_win) begin
            o_min_val <= i_cand_val;
            o_min_idx <= i_cand_idx;
        end
    end
endmodule

// File: rtl/ss_sort_ctrl.sv
// Selection-sort sequencer: scans each unsorted suffix of an external sync-read RAM and swaps the winner into place.
import ss_pkg::*;

module ss_sort_ctrl #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter bit ASCEND = 1'b1,
    parameter bit SIGNED = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [DATA_W-1:0] i_rd_data,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [DATA_W-1:0] o_wr_data
);
    localparam int IDX_W = ADDR_W + 1;

    ss_state_e         r_state;
    logic [IDX_W-1:0]  r_i, r_j, r_jd;
    logic [DATA_W-1:0] r_val_i;
    logic              r_rd_valid;
    logic              w_edge, w_win, w_load, w_cand_vld;
    logic [DATA_W-1:0] w_min_val;
    logic [IDX_W-1:0]  w_min_idx, w_final_idx;

    SS_detect_edge #(.POS_EDGE(1'b1)) u_edge (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_sig  (i_start),
        .o_edge (w_edge)
    );

    assign w_load     = (r_state == CAP_I);
    assign w_cand_vld = r_rd_valid && (r_state == SCAN || r_state == DRAIN);

    ss_cmp_min #(.DATA_W(DATA_W), .IDX_W(IDX_W), .ASCEND(ASCEND), .SIGNED(SIGNED)) u_cmp (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_load    (w_load),
        .i_load_val(i_rd_data),
        .i_load_idx(r_i),
        .i_cand_vld(w_cand_vld),
        .i_cand_val(i_rd_data),
        .i_cand_idx(r_jd),
        .o_win     (w_win),
        .o_min_val (w_min_val),
        .o_min_idx (w_min_idx)
    );

    // The last candidate is judged in DRAIN itself, so the swap decision looks through the pending update.
    assign w_final_idx = w_win ? r_jd : w_min_idx;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_i        <= '0;
            r_j        <= '0;
            r_jd       <= '0;
            r_val_i    <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_edge) begin
                    r_i     <= '0;
                    r_state <= RD_I;
                end
                RD_I: r_state <= CAP_I;
                CAP_I: begin
                    r_val_i    <= i_rd_data;
                    r_j        <= r_i + 1'b1;
                    r_rd_valid <= 1'b0;
                    r_state    <= SCAN;
                end
                SCAN: begin
                    r_jd       <= r_j;
                    r_rd_valid <= 1'b1;
                    if (r_j == IDX_W'(DEPTH - 1)) r_state <= DRAIN;
                    else                          r_j     <= r_j + 1'b1;
                end
                DRAIN: begin
                    r_rd_valid <= 1'b0;
                    r_state    <= (w_final_idx != r_i) ? SWAP_A : NEXT;
                end
                SWAP_A: r_state <= SWAP_B;
                SWAP_B: r_state <= NEXT;
                NEXT: begin
                    if (r_i == IDX_W'(DEPTH - 2)) begin
                        r_state <= DONE;
                    end else begin
                        r_i     <= r_i + 1'b1;
                        r_state <= RD_I;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        o_rd_en   = 1'b0;
        o_rd_addr = '0;
        o_wr_en   = 1'b0;
        o_wr_addr = '0;
        o_wr_data = '0;
        case (r_state)
            RD_I: begin
                o_rd_en   = 1'b1;
                o_rd_addr = r_i[ADDR_W-1:0];
            end
            SCAN: begin
                o_rd_en   = 1'b1;
                o_rd_addr = r_j[ADDR_W-1:0];
            end
            SWAP_A: begin
                o_wr_en   = 1'b1;
                o_wr_addr = r_i[ADDR_W-1:0];
                o_wr_data = w_min_val;
            end
            SWAP_B: begin
                o_wr_en   = 1'b1;
                o_wr_addr = w_min_idx[ADDR_W-1:0];
                o_wr_data = r_val_i;
            end
            default: ;
        endcase
    end

    assign o_busy = (r_state != IDLE);
    assign o_done = (r_state == DONE);
endmodule
